// File: rtl/song_addr_sequencer_if.sv
// Control/status bundle between the user-control FSM, the address sequencer
// and the note ROM. The master drives song table, transport controls and beat
// tick; the slave (sequencer) returns the ROM address and play status.
interface song_addr_sequencer_if #(
   parameter int ADDR_W   = 10,
   parameter int SONG_NUM = 4,
   parameter int SEL_W    = 2
);
   logic                       BEAT_EN;
   logic [SEL_W-1:0]           SONG_SEL;
   logic [SONG_NUM*ADDR_W-1:0] SONG_START;
   logic [SONG_NUM*ADDR_W-1:0] SONG_END;
   logic                       PLAY;
   logic                       PAUSE;
   logic                       STOP;
   logic                       LOOP_MODE;
   logic [ADDR_W-1:0]          ROM_ADDR;
   logic [SEL_W-1:0]           CUR_SONG;
   logic                       PLAYING;
   logic                       SONG_DONE;
   logic                       TBL_ERR;

   modport master (
      output BEAT_EN, SONG_SEL, SONG_START, SONG_END, PLAY, PAUSE, STOP, LOOP_MODE,
      input  ROM_ADDR, CUR_SONG, PLAYING, SONG_DONE, TBL_ERR
   );

   modport slave (
      input  BEAT_EN, SONG_SEL, SONG_START, SONG_END, PLAY, PAUSE, STOP, LOOP_MODE,
      output ROM_ADDR, CUR_SONG, PLAYING, SONG_DONE, TBL_ERR
   );
endinterface

// File: rtl/song_addr_sequencer.sv
// Music-ROM address sequencer: steps the ROM address once per beat tick inside
// the selected song's [start, end] range, with play/pause/stop, loop mode,
// restart on song change, table-error detection and a per-song done pulse.
// Optional build macro SONG_AUTO_NEXT_EN: a single-shot song that finishes
// advances to the next song (wrapping) instead of parking in DONE.
module song_addr_sequencer #(
   parameter int ADDR_W   = 10,
   parameter int SONG_NUM = 4,
   parameter int SEL_W    = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   song_addr_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_HOLD,
      S_DONE
   } state_t;

   state_t             state, state_nx;
   logic [ADDR_W-1:0]  addr, addr_nx;
   logic [ADDR_W-1:0]  start_cur, end_cur;
   logic [SEL_W-1:0]   song, song_nx;
   logic [SEL_W-1:0]   sel_q;
   logic               done, done_nx;
   logic               err, err_nx;
   logic               play_q;
   logic               sel_chg;
   logic               out_rng;
`ifdef SONG_AUTO_NEXT_EN
   logic [SEL_W-1:0]   song_inc;

   assign song_inc = (song == SEL_W'(SONG_NUM - 1)) ? '0 : song + SEL_W'(1);
`endif

   assign sel_chg = (bus.SONG_SEL != sel_q);
   // Table may be edited live, so the current address can fall outside it.
   assign out_rng = (addr < start_cur) || (addr > end_cur);

   // Look up the current song's start/end from the flattened table.
   always_comb begin
      start_cur = '0;
      end_cur   = '0;
      for (int i = 0; i < SONG_NUM; i++) begin
         if (song == SEL_W'(i)) begin
            start_cur = bus.SONG_START[i*ADDR_W +: ADDR_W];
            end_cur   = bus.SONG_END[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Next-state, next-address and pulse decode; STOP beats everything.
   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      song_nx  = song;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (bus.STOP) begin
         state_nx = S_IDLE;
         addr_nx  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.PLAY) begin
                  song_nx  = bus.SONG_SEL;
                  state_nx = S_LOAD;
               end
            end
            S_LOAD: begin
               if (start_cur > end_cur) begin
                  err_nx   = 1'b1;
                  addr_nx  = '0;
                  state_nx = S_IDLE;
               end else begin
                  addr_nx  = start_cur;
                  state_nx = S_RUN;
               end
            end
            S_RUN: begin
               if (sel_chg) begin
                  song_nx  = bus.SONG_SEL;
                  state_nx = S_LOAD;
               end else if (bus.PAUSE) begin
                  state_nx = S_HOLD;
               end else if (out_rng) begin
                  addr_nx = start_cur;
               end else if (bus.BEAT_EN) begin
                  if (addr == end_cur) begin
                     done_nx = 1'b1;
                     if (bus.LOOP_MODE) begin
                        addr_nx = start_cur;
                     end else begin
`ifdef SONG_AUTO_NEXT_EN
                        song_nx  = song_inc;
                        state_nx = S_LOAD;
`else
                        state_nx = S_DONE;
`endif
                     end
                  end else begin
                     addr_nx = addr + ADDR_W'(1);
                  end
               end
            end
            S_HOLD: begin
               if (sel_chg) begin
                  song_nx  = bus.SONG_SEL;
                  state_nx = S_LOAD;
               end else if (!bus.PAUSE) begin
                  state_nx = S_RUN;
               end
            end
            S_DONE: begin
               if (sel_chg) begin
                  song_nx  = bus.SONG_SEL;
                  state_nx = S_LOAD;
               end else if (bus.PLAY && !play_q) begin
                  state_nx = S_LOAD;
               end
            end
            default: begin
               state_nx = S_IDLE;
               addr_nx  = '0;
            end
         endcase
      end
   end

   // State, address and registered status pulses; selector/play history.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         addr   <= '0;
         song   <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
         sel_q  <= '0;
         play_q <= 1'b0;
      end else begin
         state  <= state_nx;
         addr   <= addr_nx;
         song   <= song_nx;
         done   <= done_nx;
         err    <= err_nx;
         sel_q  <= bus.SONG_SEL;
         play_q <= bus.PLAY;
      end
   end

   assign bus.ROM_ADDR  = addr;
   assign bus.CUR_SONG  = song;
   assign bus.PLAYING   = (state == S_RUN);
   assign bus.SONG_DONE = done;
   assign bus.TBL_ERR   = err;

endmodule

// File: tb/tb_song_addr_sequencer.sv
// Scoreboard bench for song_addr_sequencer: directed scenarios plus a random
// phase, each cycle's expected outputs produced by a behavioural player model.
module tb_song_addr_sequencer;
   localparam int ADDR_W   = 10;
   localparam int SONG_NUM = 4;
   localparam int SEL_W    = 2;
   localparam int AMAX     = (1 << ADDR_W) - 1;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;
   localparam int M_HOLD = 3;
   localparam int M_DONE = 4;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   bit   clk_en = 1'b1;
   bit   mon_en = 1'b0;

   song_addr_sequencer_if #(.ADDR_W(ADDR_W), .SONG_NUM(SONG_NUM), .SEL_W(SEL_W)) bus ();

   song_addr_sequencer #(.ADDR_W(ADDR_W), .SONG_NUM(SONG_NUM), .SEL_W(SEL_W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 if (clk_en) CLK = ~CLK;

   // Stimulus variables
   int st[SONG_NUM];
   int en[SONG_NUM];
   bit t_beat, t_play, t_pause, t_stop, t_loop;
   int t_sel;

   // Player model
   int m_mode, m_addr, m_song, m_selq;
   bit m_playq, m_done, m_err;

   typedef struct {
      int addr;
      int song;
      int playing;
      int done;
      int err;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < SONG_NUM; i++) begin
         bus.SONG_START[i*ADDR_W +: ADDR_W] = st[i][ADDR_W-1:0];
         bus.SONG_END[i*ADDR_W +: ADDR_W]   = en[i][ADDR_W-1:0];
      end
      bus.BEAT_EN   = t_beat;
      bus.SONG_SEL  = t_sel[SEL_W-1:0];
      bus.PLAY      = t_play;
      bus.PAUSE     = t_pause;
      bus.STOP      = t_stop;
      bus.LOOP_MODE = t_loop;
   endtask

   // One clock of the player as a user would describe it.
   task automatic model_step();
      int lo, hi, n_mode, n_addr, n_song;
      bit changed;
      exp_t e;
      lo = st[m_song];
      hi = en[m_song];
      changed = (t_sel != m_selq);
      n_mode = m_mode;
      n_addr = m_addr;
      n_song = m_song;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (t_stop) begin
         n_mode = M_IDLE;
         n_addr = 0;
      end else if (m_mode == M_IDLE) begin
         if (t_play) begin
            n_song = t_sel;
            n_mode = M_LOAD;
         end
      end else if (m_mode == M_LOAD) begin
         if (lo > hi) begin
            m_err  = 1'b1;
            n_addr = 0;
            n_mode = M_IDLE;
         end else begin
            n_addr = lo;
            n_mode = M_RUN;
         end
      end else if (changed) begin
         n_song = t_sel;
         n_mode = M_LOAD;
      end else if (m_mode == M_HOLD) begin
         if (!t_pause) n_mode = M_RUN;
      end else if (m_mode == M_DONE) begin
         if (t_play && !m_playq) n_mode = M_LOAD;
      end else begin
         if (t_pause) n_mode = M_HOLD;
         else if (m_addr < lo || m_addr > hi) n_addr = lo;
         else if (t_beat) begin
            if (m_addr == hi) begin
               m_done = 1'b1;
               if (t_loop) n_addr = lo;
               else begin
`ifdef SONG_AUTO_NEXT_EN
                  n_song = (m_song + 1) % SONG_NUM;
                  n_mode = M_LOAD;
`else
                  n_mode = M_DONE;
`endif
               end
            end else begin
               n_addr = m_addr + 1;
            end
         end
      end
      m_mode  = n_mode;
      m_addr  = n_addr;
      m_song  = n_song;
      m_selq  = t_sel;
      m_playq = t_play;
      e.addr    = m_addr;
      e.song    = m_song;
      e.playing = (m_mode == M_RUN) ? 1 : 0;
      e.done    = m_done ? 1 : 0;
      e.err     = m_err ? 1 : 0;
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      apply();
      model_step();
      @(negedge CLK);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic beats(input int n);
      repeat (n) begin
         t_beat = 1'b1; cycle();
         t_beat = 1'b0; cycle();
      end
   endtask

   task automatic pulse_stop();
      t_stop = 1'b1; cycle();
      t_stop = 1'b0; cycle();
   endtask

   task automatic start_song(input int s);
      t_sel = s;      cycle();
      t_play = 1'b1;  cycle();
      t_play = 1'b0;  cycle();
      cycle();
   endtask

   // Monitor: every clock the DUT presents a fresh output set.
   always @(posedge CLK) begin
      if (mon_en) begin
         #1;
         if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rom_addr",  int'(bus.ROM_ADDR),  e.addr);
            chk("cur_song",  int'(bus.CUR_SONG),  e.song);
            chk("playing",   int'(bus.PLAYING),   e.playing);
            chk("song_done", int'(bus.SONG_DONE), e.done);
            chk("tbl_err",   int'(bus.TBL_ERR),   e.err);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      st = '{0, 139, 336, 400};
      en = '{138, 335, 500, 402};
      t_beat = 0; t_play = 0; t_pause = 0; t_stop = 0; t_loop = 0; t_sel = 0;
      m_mode = M_IDLE; m_addr = 0; m_song = 0; m_selq = 0;
      m_playq = 0; m_done = 0; m_err = 0;
      apply();
      repeat (3) @(negedge CLK);
      chk("reset_rom_addr",  int'(bus.ROM_ADDR),  0);
      chk("reset_cur_song",  int'(bus.CUR_SONG),  0);
      chk("reset_playing",   int'(bus.PLAYING),   0);
      chk("reset_song_done", int'(bus.SONG_DONE), 0);
      chk("reset_tbl_err",   int'(bus.TBL_ERR),   0);
      RST_N  = 1'b1;
      mon_en = 1'b1;

      // Single-shot song0 to DONE
      start_song(0);
      beats(139);
      run(4);

      // Looping song1 wraps back to its start
      pulse_stop();
      t_loop = 1'b1;
      start_song(1);
      beats(197);
      beats(3);

      // Song change mid-play, then alternating selection
      pulse_stop();
      t_loop = 1'b0;
      start_song(0);
      beats(50);
      t_sel = 1;
      run(3);
      beats(1);
      for (int k = 0; k < 6; k++) begin
         t_sel = (t_sel == 0) ? 1 : 0;
         beats(10);
      end

      // Pause holds the address, release resumes, stop clears
      pulse_stop();
      start_song(0);
      beats(20);
      t_pause = 1'b1;
      beats(10);
      t_pause = 1'b0;
      run(2);
      beats(1);
      pulse_stop();

      // Bad table entry
      st[2] = 300; en[2] = 200;
      start_song(2);
      run(2);
      st[2] = 336; en[2] = 500;

      // Short song3 end (auto-advance when that build option is present)
      pulse_stop();
      start_song(3);
      beats(4);
      run(4);

      // Random phase with edge-of-range table entries
      pulse_stop();
      st[2] = AMAX - 5; en[2] = AMAX;
      st[3] = 7;        en[3] = 7;
      t_loop = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         t_beat = (($urandom % 3) == 0);
         t_stop = (($urandom % 80) == 0);
         t_play = (($urandom % 6) == 0);
         if (($urandom % 100) == 0) t_sel = int'($urandom % SONG_NUM);
         if (($urandom % 10) == 0)  t_pause = (($urandom % 4) == 0);
         if (($urandom % 200) == 0) t_loop = ~t_loop;
         if (($urandom % 300) == 0) begin
            int s, kind;
            s = int'($urandom % SONG_NUM);
            kind = int'($urandom % 4);
            if (kind == 0) begin
               st[s] = int'($urandom % 1000);
               en[s] = st[s] + int'($urandom % 20);
            end else if (kind == 1) begin
               st[s] = int'($urandom % 1024);
               en[s] = st[s];
            end else if (kind == 2) begin
               en[s] = AMAX;
               st[s] = AMAX - int'($urandom % 8);
            end else begin
               st[s] = 500;
               en[s] = 490;
            end
         end
         cycle();
      end

      // Restore a sane table, play, then async reset with the clock stopped
      t_beat = 0; t_play = 0; t_pause = 0; t_stop = 0;
      st = '{0, 139, 336, 400};
      en = '{138, 335, 500, 402};
      pulse_stop();
      start_song(0);
      beats(5);
      mon_en = 1'b0;
      clk_en = 1'b0;
      chk("queue_drain", exp_q.size(), 0);
      chk("pre_reset_playing", int'(bus.PLAYING), 1);
      chk("pre_reset_rom_addr", int'(bus.ROM_ADDR), 5);
      #3;
      RST_N = 1'b0;
      #1;
      chk("async_rom_addr",  int'(bus.ROM_ADDR),  0);
      chk("async_cur_song",  int'(bus.CUR_SONG),  0);
      chk("async_playing",   int'(bus.PLAYING),   0);
      chk("async_song_done", int'(bus.SONG_DONE), 0);
      chk("async_tbl_err",   int'(bus.TBL_ERR),   0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/song_addr_sequencer.md
Name: song_addr_sequencer

Overview:
- Parametrised music-ROM address sequencer for the song player. It supersedes the fixed two-song length counter.
- Holds a table of SONG_NUM songs, each with its own start/end ROM address. Steps the ROM address once per beat tick inside the selected song's range.
- Adds play/pause/stop control, loop mode, song-change restart, table-error detection and a per-song done pulse.
- Sits between the user-control FSM and the note ROM; the tone divider consumes ROM data.

Parameters:
ADDR_W, 10, ROM address width
SONG_NUM, 4, number of songs in the table (>=2)
SEL_W, 2, song-select width; must satisfy 2^SEL_W >= SONG_NUM

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
BEAT_EN  input  1  one-CLK-wide beat tick (4 Hz rate)
SONG_SEL  input  SEL_W  requested song index
SONG_START  input  SONG_NUM*ADDR_W  flattened start addresses; song i at bits [i*ADDR_W +: ADDR_W]
SONG_END  input  SONG_NUM*ADDR_W  flattened end addresses, same packing
PLAY  input  1  level; start/resume playback
PAUSE  input  1  level; freeze address while high
STOP  input  1  pulse; abort to idle
LOOP_MODE  input  1  1 = restart song at end; 0 = single-shot
ROM_ADDR  output  ADDR_W  current ROM address
CUR_SONG  output  SEL_W  index of the song being played
PLAYING  output  1  high in RUN state
SONG_DONE  output  1  one-cycle pulse when the last note's beat completes
TBL_ERR  output  1  one-cycle pulse when the loaded song has start > end

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous, active-low.
- Reset values: ROM_ADDR=0, CUR_SONG=0, PLAYING=0, SONG_DONE=0, TBL_ERR=0, state=IDLE, sel_q=0.
- States: IDLE, LOAD, RUN, HOLD, DONE.
- IDLE:
  - PLAY=1 -> latch CUR_SONG<=SONG_SEL, go to LOAD.
- LOAD (one cycle):
  - If start[CUR_SONG] > end[CUR_SONG]: TBL_ERR=1 this cycle, ROM_ADDR<=0, go to IDLE.
  - Else ROM_ADDR<=start[CUR_SONG], go to RUN.
  - PLAYING goes high on the cycle after LOAD.
- RUN:
  - PAUSE=1 -> HOLD. Address frozen; a BEAT_EN in the same cycle is ignored.
  - BEAT_EN with ROM_ADDR != end -> ROM_ADDR+1.
  - BEAT_EN with ROM_ADDR == end -> SONG_DONE=1 for that cycle. Then:
    - LOOP_MODE=1: ROM_ADDR<=start, stay in RUN.
    - LOOP_MODE=0: go to DONE, ROM_ADDR held at end.
  - Out-of-range guard: ROM_ADDR < start or > end (table edited live) -> ROM_ADDR<=start on the next cycle, no SONG_DONE.
- HOLD:
  - PAUSE=0 -> RUN. Beats received while in HOLD are dropped, not queued.
- DONE:
  - PLAYING=0.
  - PLAY rising edge -> LOAD with the same CUR_SONG, unless SONG_SEL differs (see song change).
- Song change: sel_q is a registered copy of SONG_SEL.
  - SONG_SEL != sel_q in RUN, HOLD or DONE -> CUR_SONG<=SONG_SEL, go to LOAD.
  - The new song starts at its start address, and a pause is cancelled.
  - In IDLE, a song change only updates sel_q.
- STOP: from any state, next cycle -> IDLE, ROM_ADDR=0, PLAYING=0.
- Priority within one cycle: STOP > song change > PAUSE > BEAT_EN > PLAY.
- Arithmetic:
  - ROM_ADDR increments only up to end, so no wrap past 2^ADDR_W-1; end = all-ones is legal.
  - start == end is a one-note song: SONG_DONE on every beat in loop mode.
- SONG_DONE and TBL_ERR are registered outputs and never high for two consecutive cycles.

Optional Feature:
- Macro: SONG_AUTO_NEXT_EN.
- Defined: at song end with LOOP_MODE=0, instead of DONE:
  - CUR_SONG<=CUR_SONG+1, wrapping SONG_NUM-1 -> 0.
  - Go to LOAD; SONG_DONE still pulses.
  - sel_q is not updated, so no spurious song-change reload.
- Undefined: single-shot ends in DONE as described under Behaviour.

Test Plan:
- Table song0=0..138, song1=139..335. Reset; PLAY, SONG_SEL=0, LOOP_MODE=0; 139 beats -> ROM_ADDR 0->138. SONG_DONE one cycle on the 139th beat, then state DONE with ROM_ADDR=138 and PLAYING=0.
- Same table, LOOP_MODE=1, song1 -> after 197 beats ROM_ADDR returns to 139 with a SONG_DONE pulse, and PLAYING stays 1.
- Playing song0 at ROM_ADDR=50, switch SONG_SEL to 1 -> LOAD, then ROM_ADDR=139. Next beat -> 140. Alternate SONG_SEL every 20 CLK -> the address always restarts at 0 or 139.
- PAUSE held for 10 beats at ROM_ADDR=20 -> ROM_ADDR stays 20. Release, one beat -> 21. STOP at 21 -> next cycle ROM_ADDR=0, IDLE.
- Song2 start=300, end=200, PLAY -> TBL_ERR one cycle, IDLE, ROM_ADDR=0. Assert RST_N low mid-RUN with CLK stopped -> all outputs 0 immediately.
- With SONG_AUTO_NEXT_EN, song3=400..402, LOOP_MODE=0 -> after song3's last beat, CUR_SONG=0 and ROM_ADDR=0 with one SONG_DONE.
